bcd_multidigit_counter: RTL and testbench
=========================================

# bcd_multidigit_counter

Parametrised synchronous N-digit BCD counter: a generalisation of the single-digit 4-bit BCD counter used to drive the seven-segment display. It adds a digit count, count enable, up/down direction, synchronous parallel load with BCD validation, selectable wrap or saturate at the range limits, and cascade/overflow outputs. It sits between the clock-enable/tick generator and the seven-segment multiplexer, which consumes `Q` one nibble per digit.

## Interface

- `DIGITS`, default 4: number of BCD digits. Legal range 1..8. Count range 0 .. 10^DIGITS-1.
- `WRAP`, default 1: 1 = wrap at the range limits; 0 = saturate at the range limits.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `en`  input  1  count enable; one step per rising `clk` edge while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement. Sampled only when `en`=1.
- `load`  input  1  synchronous parallel load; overrides `en`.
- `load_val`  input  4*DIGITS  value to load; nibble k is digit k, with digit 0 least significant.
- `Q`  output  4*DIGITS  registered count; nibble k is digit k. Each nibble is always 0..9.
- `tc`  output  1  combinational terminal count: `en` & (`up` ? all digits = 9 : all digits = 0). Used for cascading further counters.
- `ovf`  output  1  registered one-cycle pulse marking a boundary event (wrap or saturation attempt).
- `load_err`  output  1  registered one-cycle pulse: the last load contained at least one nibble > 9.

## Operation

- While `reset`=0, regardless of `clk`: `Q`=0, `ovf`=0, `load_err`=0. Release of reset is followed by normal operation at the next rising edge.
- Actions at each rising edge, highest priority first:
  1. `load`=1: each digit k takes `load_val` nibble k if that nibble is ≤ 9, otherwise 0. `load_err` is 1 if any nibble was > 9, otherwise 0. `ovf` is 0. `en` and `up` are ignored.
  2. `en`=1, `up`=1: BCD increment. Digit 0 adds 1. A digit at 9 goes to 0 and carries into the next digit. A carry out of the top digit is a boundary event.
  3. `en`=1, `up`=0: BCD decrement. Digit 0 subtracts 1. A digit at 0 goes to 9 and borrows from the next digit. A borrow out of the top digit is a boundary event.
  4. Otherwise: `Q` holds. `ovf`=0 and `load_err`=0.
- Boundary event, incrementing from all 9s:
  - `WRAP`=1: `Q` becomes all 0s.
  - `WRAP`=0: `Q` stays at all 9s.
  - In both modes `ovf`=1 for that cycle.
- Boundary event, decrementing from all 0s:
  - `WRAP`=1: `Q` becomes all 9s.
  - `WRAP`=0: `Q` stays at all 0s.
  - In both modes `ovf`=1 for that cycle.
- `ovf` and `load_err` are 0 in every cycle not described above. They never stay high for two cycles unless the triggering condition recurs on consecutive edges. Sitting saturated with `en`=1 raises `ovf` on every edge.
- Arithmetic is per-digit only. No binary adder over the full `Q` width is used. Each nibble result is reduced to the range 0..9 within the same cycle.
- `tc` depends only on the current `Q`, `en` and `up`. It has no register, so a downstream counter enabled by `tc` steps on the same edge that this counter wraps.

## Timing

- Latency is one cycle from an input sampled at edge n to a `Q` change visible after edge n.
- `ovf` and `load_err` are registered. They become valid in the same cycle as the `Q` value produced by the triggering edge.
- `tc` is valid combinationally within the current cycle. There is no setup relationship to `ovf`.
- Reset assertion mid-count clears `Q`, `ovf` and `load_err` immediately, without waiting for an edge. The first count after release occurs on the first edge where `reset`=1 and `en`=1.
- Simultaneous events:
  - `load` with `en`: load wins and no count occurs.
  - `load` of all 9s with `en`=1, `up`=1: `Q` = all 9s and `ovf`=0.
- Direction may change on any edge. No dead cycle is required.

## Test plan

All scenarios use `DIGITS`=4.

- Reset, count up, toggle direction: assert `reset`=0, then release. Hold `en`=1, `up`=1 for 12 edges → `Q`=0x0012. Set `up`=0 for 3 edges → `Q`=0x0009. Check that no nibble ever exceeds 9.
- Up wrap and cascade, `WRAP`=1: load 0x9998, then `en`=1, `up`=1.
  - Edge 1 → `Q`=0x9999 and `tc`=1.
  - Edge 2 → `Q`=0x0000 and `ovf`=1 for exactly one cycle.
- Down wrap, `WRAP`=1: load 0x0001, then `en`=1, `up`=0.
  - Edge 1 → `Q`=0x0000 and `tc`=1.
  - Edge 2 → `Q`=0x9999 and `ovf`=1.
- Saturation, `WRAP`=0: load 0x9999 and hold `en`=1, `up`=1 for 3 edges → `Q` stays 0x9999 and `ovf`=1 on each edge. Repeat with 0x0000 and `up`=0 → `Q` stays 0x0000.
- Invalid load and priority:
  - `load`=1 with `load_val`=0x3A7F → `Q`=0x3070 and `load_err`=1 for one cycle.
  - `load`=1 with `en`=1, `load_val`=0x1234 → `Q`=0x1234 with no increment.
- Mid-operation reset: while counting at 0x0456, drive `reset`=0 between edges → `Q`=0x0000 immediately. Release → counting resumes 0x0001, 0x0002, and so on.

Source files
------------

// File: rtl/bcd_multidigit_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_multidigit_counter_if
//
// Bundles the control and data signals of the N-digit BCD counter so that a
// driver (tick generator / loader) and the counter share one connection.
//
// Signals:
//   en        count enable, one step per clock edge while high
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous parallel load, takes priority over en
//   load_val  value to load, nibble k is digit k (digit 0 least significant)
//   Q         registered count, nibble k is digit k, each nibble 0..9
//   tc        combinational terminal count for cascading
//   ovf       registered one-cycle boundary pulse (wrap or saturation attempt)
//   load_err  registered one-cycle pulse, last load held a nibble above 9
//
// Modports:
//   master  drives the controls and observes the counter outputs
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface bcd_multidigit_counter_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   Q;
   logic                  tc;
   logic                  ovf;
   logic                  load_err;

   modport master (
      output en, up, load, load_val,
      input  Q, tc, ovf, load_err
   );

   modport slave (
      input  en, up, load, load_val,
      output Q, tc, ovf, load_err
   );
endinterface

// File: rtl/bcd_multidigit_counter.sv
// ---------------------------------------------------------------------------
// bcd_multidigit_counter
//
// Parametrised N-digit BCD up/down counter feeding the seven-segment
// multiplexer. Supports count enable, direction, synchronous parallel load
// with per-nibble BCD validation, wrap or saturate at the range limits, a
// combinational terminal count for cascading and registered overflow and
// load-error pulses.
//
// Parameters:
//   DIGITS  number of BCD digits (1..8)
//   WRAP    1 = wrap at the range limits, 0 = saturate
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 clears Q, ovf, load_err)
//   bus    slave side of bcd_multidigit_counter_if (en, up, load, load_val,
//          Q, tc, ovf, load_err)
// ---------------------------------------------------------------------------
module bcd_multidigit_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   bcd_multidigit_counter_if.slave  bus
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] count_q;
   logic         ovf_q;
   logic         load_err_q;

   logic [W-1:0] step_q;
   logic         boundary;
   logic [W-1:0] load_q;
   logic         load_bad;
   logic         all_nine;
   logic         all_zero;

   // Ripple the carry (or borrow) digit by digit. Each digit is handled on
   // its own nibble so results never leave 0..9. Whatever is still pending
   // after the top digit marks a boundary event: for increments this only
   // happens from all nines, for decrements only from all zeros, and the
   // rippled value is already the wrapped result in both directions.
   always_comb begin
      logic       pend;
      logic [3:0] cur;
      logic [3:0] nxt;
      step_q = count_q;
      pend   = 1'b1;
      cur    = 4'd0;
      nxt    = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         cur = count_q[4*k +: 4];
         nxt = cur;
         if (pend) begin
            if (bus.up) begin
               if (cur >= 4'd9) begin
                  nxt = 4'd0;
               end else begin
                  nxt  = cur + 4'd1;
                  pend = 1'b0;
               end
            end else begin
               if (cur == 4'd0) begin
                  nxt = 4'd9;
               end else if (cur > 4'd9) begin
                  nxt  = 4'd9;
                  pend = 1'b0;
               end else begin
                  nxt  = cur - 4'd1;
                  pend = 1'b0;
               end
            end
         end
         step_q[4*k +: 4] = nxt;
      end
      boundary = pend;
   end

   // Load path: every nibble above 9 is replaced by 0 and flagged, the
   // remaining nibbles are taken as they are.
   always_comb begin
      logic [3:0] nib;
      load_q   = '0;
      load_bad = 1'b0;
      nib      = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         nib = bus.load_val[4*k +: 4];
         if (nib > 4'd9) begin
            load_q[4*k +: 4] = 4'd0;
            load_bad         = 1'b1;
         end else begin
            load_q[4*k +: 4] = nib;
         end
      end
   end

   // Terminal count is deliberately unregistered so a downstream counter
   // enabled by tc steps on the same edge this counter wraps.
   assign all_nine = (count_q == {DIGITS{4'h9}});
   assign all_zero = (count_q == '0);
   assign bus.tc   = bus.en & (bus.up ? all_nine : all_zero);

   // State register. Load beats counting; the pulses default to 0 every
   // edge so they last exactly one cycle unless their cause repeats. In
   // saturate mode a boundary step leaves the count where it is but still
   // reports ovf.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q    <= '0;
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
         if (bus.load) begin
            count_q    <= load_q;
            load_err_q <= load_bad;
         end else if (bus.en) begin
            ovf_q <= boundary;
            if (!boundary || WRAP) begin
               count_q <= step_q;
            end
         end
      end
   end

   assign bus.Q        = count_q;
   assign bus.ovf      = ovf_q;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_multidigit_counter
//
// Drives a wrapping and a saturating 4-digit counter with identical stimulus.
// The expected outputs come from an integer model of the count value; each
// stimulus cycle pushes its expectation into a queue that a separate monitor
// pops one clock edge later.
// ---------------------------------------------------------------------------
module tb_bcd_multidigit_counter;

   localparam int DIGITS = 4;
   localparam int MAXVAL = 9999;

   typedef struct {
      logic [15:0] qWrap;
      logic [15:0] qSat;
      logic        ovfWrap;
      logic        ovfSat;
      logic        err;
      logic        tcWrap;
      logic        tcSat;
   } exp_t;

   logic clk;
   logic reset;

   bcd_multidigit_counter_if #(.DIGITS(DIGITS)) busWrap ();
   bcd_multidigit_counter_if #(.DIGITS(DIGITS)) busSat ();

   bcd_multidigit_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) dutWrap (
      .clk   (clk),
      .reset (reset),
      .bus   (busWrap)
   );

   bcd_multidigit_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) dutSat (
      .clk   (clk),
      .reset (reset),
      .bus   (busSat)
   );

   exp_t sbQueue[$];
   int   modelWrap;
   int   modelSat;
   bit   stimDone;
   int   checks;
   int   errors;

   // 10-unit clock period: rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Converts an integer count into its packed BCD digits.
   function automatic logic [15:0] toBcd(input int v);
      logic [15:0] r;
      int          t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // One edge of the reference model on a plain integer value in 0..9999.
   function automatic int stepModel(input int cur, input bit wrapMode,
                                    input bit ld, input logic [15:0] lv,
                                    input bit en, input bit up,
                                    output bit ovfOut, output bit errOut);
      int value;
      int scale;
      int nib;
      ovfOut = 1'b0;
      errOut = 1'b0;
      if (ld) begin
         value = 0;
         scale = 1;
         for (int k = 0; k < DIGITS; k++) begin
            nib = int'(lv[4*k +: 4]);
            if (nib > 9) errOut = 1'b1;
            else         value  = value + nib * scale;
            scale = scale * 10;
         end
         return value;
      end
      if (!en) return cur;
      if (up) begin
         if (cur == MAXVAL) begin
            ovfOut = 1'b1;
            return wrapMode ? 0 : MAXVAL;
         end
         return cur + 1;
      end
      if (cur == 0) begin
         ovfOut = 1'b1;
         return wrapMode ? MAXVAL : 0;
      end
      return cur - 1;
   endfunction

   // Drives one cycle of inputs on the falling edge and queues what both
   // counters must show after the following rising edge.
   task automatic applyStimulus(input bit ld, input logic [15:0] lv,
                                input bit en, input bit up);
      exp_t e;
      bit   ovfW, ovfS, errW, errS;
      @(negedge clk);
      busWrap.load = ld;  busWrap.load_val = lv;  busWrap.en = en;  busWrap.up = up;
      busSat.load  = ld;  busSat.load_val  = lv;  busSat.en  = en;  busSat.up  = up;
      modelWrap = stepModel(modelWrap, 1'b1, ld, lv, en, up, ovfW, errW);
      modelSat  = stepModel(modelSat,  1'b0, ld, lv, en, up, ovfS, errS);
      e.qWrap   = toBcd(modelWrap);
      e.qSat    = toBcd(modelSat);
      e.ovfWrap = ovfW;
      e.ovfSat  = ovfS;
      e.err     = errW;
      e.tcWrap  = en && (up ? (modelWrap == MAXVAL) : (modelWrap == 0));
      e.tcSat   = en && (up ? (modelSat  == MAXVAL) : (modelSat  == 0));
      sbQueue.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkDigits(input string name, input logic [15:0] act);
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (act[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s nibble above 9: actual=%h at %0t", name, act, $time);
      end
   endtask

   // Monitor: while reset is low both counters must read all zeros; after
   // each active edge pop one expectation and compare every output.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge reset);
         #1;
         if (!reset) begin
            checkOutput("reset_q_wrap",   busWrap.Q, 16'h0000);
            checkOutput("reset_q_sat",    busSat.Q,  16'h0000);
            checkOutput("reset_ovf_wrap", {15'd0, busWrap.ovf}, 16'h0000);
            checkOutput("reset_ovf_sat",  {15'd0, busSat.ovf},  16'h0000);
            checkOutput("reset_err_wrap", {15'd0, busWrap.load_err}, 16'h0000);
         end else if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput("q_wrap",   busWrap.Q, e.qWrap);
            checkOutput("q_sat",    busSat.Q,  e.qSat);
            checkOutput("ovf_wrap", {15'd0, busWrap.ovf}, {15'd0, e.ovfWrap});
            checkOutput("ovf_sat",  {15'd0, busSat.ovf},  {15'd0, e.ovfSat});
            checkOutput("err_wrap", {15'd0, busWrap.load_err}, {15'd0, e.err});
            checkOutput("err_sat",  {15'd0, busSat.load_err},  {15'd0, e.err});
            checkOutput("tc_wrap",  {15'd0, busWrap.tc}, {15'd0, e.tcWrap});
            checkOutput("tc_sat",   {15'd0, busSat.tc},  {15'd0, e.tcSat});
            checkDigits("digits_wrap", busWrap.Q);
            checkDigits("digits_sat",  busSat.Q);
         end else if (stimDone) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   // Bound on the whole run so a stuck bench still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before stimulus completed");
      $fatal(1, "[TB] watchdog");
   end

   // Stimulus: directed scenarios first, then randomized cycles.
   initial begin
      logic [15:0] lv;
      int          r;
      stimDone  = 1'b0;
      checks    = 0;
      errors    = 0;
      modelWrap = 0;
      modelSat  = 0;
      reset     = 1'b1;
      busWrap.load = 1'b0; busWrap.load_val = '0; busWrap.en = 1'b0; busWrap.up = 1'b1;
      busSat.load  = 1'b0; busSat.load_val  = '0; busSat.en  = 1'b0; busSat.up  = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      $display("[TB] count up 12, down 3");
      repeat (12) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
      repeat (3)  applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

      $display("[TB] up boundary from 9998");
      applyStimulus(1'b1, 16'h9998, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);

      $display("[TB] down boundary from 0001");
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
      repeat (4) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

      $display("[TB] invalid load and priority");
      applyStimulus(1'b1, 16'h3A7F, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1);
      applyStimulus(1'b1, 16'h9999, 1'b1, 1'b1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

      $display("[TB] mid-count reset");
      applyStimulus(1'b1, 16'h0450, 1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
      @(posedge clk);
      #3;
      busWrap.en = 1'b0;
      busSat.en  = 1'b0;
      reset      = 1'b0;
      modelWrap  = 0;
      modelSat   = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);

      $display("[TB] randomized cycles");
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            applyStimulus(1'b1, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         end else if (r == 1) begin
            if ($urandom_range(0, 1) == 1) lv = toBcd(MAXVAL - int'($urandom_range(0, 2)));
            else                           lv = toBcd(int'($urandom_range(0, 2)));
            applyStimulus(1'b1, lv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus(1'b0, 16'($urandom), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
         end
      end

      @(negedge clk);
      busWrap.en = 1'b0;
      busSat.en  = 1'b0;
      busWrap.load = 1'b0;
      busSat.load  = 1'b0;
      stimDone = 1'b1;
   end

endmodule
